// File: rtl/id_fwd_scoreboard.sv
// ID-stage operand forwarding and hazard unit: bypass from DEPTH in-flight stages,
// busy scoreboard for long-latency writers, and a saturating stall-cycle counter.
module id_fwd_scoreboard #(
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 4,
    parameter int NUM_RD    = 2,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 16,
    parameter int ZERO_HARD = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr,
    input  logic [NUM_RD*DATA_W-1:0] rf_data,
    input  logic [DEPTH-1:0]         st_we,
    input  logic [DEPTH*REG_AW-1:0]  st_waddr,
    input  logic [DEPTH*DATA_W-1:0]  st_wdata,
    input  logic [DEPTH-1:0]         st_ok,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic                     issue_long,
    input  logic [REG_AW-1:0]        issue_waddr,
    input  logic                     flush,
    input  logic                     lc_valid,
    input  logic [REG_AW-1:0]        lc_waddr,
    input  logic [DATA_W-1:0]        lc_wdata,
    input  logic                     stat_clr,
    output logic [NUM_RD*DATA_W-1:0] fwd_data,
    output logic                     stall_req,
    output logic                     issue_fire,
    output logic [2**REG_AW-1:0]     busy,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int NREG = 2**REG_AW;

    logic [NUM_RD-1:0]        port_haz;
    logic [NUM_RD*DATA_W-1:0] fwd_raw;
    logic [REG_AW-1:0]        addr;
    logic                     hit;
    logic                     waw_haz;
    logic [NREG-1:0]          busy_nxt;

    // The youngest matching stage owns the operand; a not-yet-valid result there
    // is a hazard even if an older stage holds good data for the same register.
    always_comb begin
        port_haz = '0;
        fwd_raw  = rf_data;
        addr     = '0;
        hit      = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            addr = rd_addr[i*REG_AW +: REG_AW];
            hit  = 1'b0;
            if (rd_en[i]) begin
                if (ZERO_HARD != 0 && addr == '0) begin
                    fwd_raw[i*DATA_W +: DATA_W] = '0;
                end else begin
                    for (int s = 0; s < DEPTH; s++) begin
                        if (!hit && st_we[s] && st_waddr[s*REG_AW +: REG_AW] == addr) begin
                            hit = 1'b1;
                            if (st_ok[s]) begin
                                fwd_raw[i*DATA_W +: DATA_W] = st_wdata[s*DATA_W +: DATA_W];
                            end else begin
                                fwd_raw[i*DATA_W +: DATA_W] = '0;
                                port_haz[i] = 1'b1;
                            end
                        end
                    end
                    if (!hit) begin
                        if (lc_valid && lc_waddr == addr) begin
                            fwd_raw[i*DATA_W +: DATA_W] = lc_wdata;
                        end else if (busy[addr]) begin
                            fwd_raw[i*DATA_W +: DATA_W] = '0;
                            port_haz[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign waw_haz    = issue_valid && issue_we && busy[issue_waddr]
                        && !(lc_valid && lc_waddr == issue_waddr);
    assign stall_req  = rst && issue_valid && ((|port_haz) || waw_haz);
    assign issue_fire = rst && issue_valid && !stall_req && !flush;
    assign fwd_data   = rst ? fwd_raw : '0;

    // Set after clear so a same-cycle completion and re-issue leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (lc_valid)
            busy_nxt[lc_waddr] = 1'b0;
        if (issue_fire && issue_we && issue_long && !(ZERO_HARD != 0 && issue_waddr == '0))
            busy_nxt[issue_waddr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= '0;
            stall_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (stat_clr)
                stall_cnt <= '0;
            else if (stall_req && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Bench for id_fwd_scoreboard: directed scenarios plus randomized traffic
// checked against a register-level behavioural model.
module tb_id_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rf_data;
    logic [1:0]  st_we;
    logic [7:0]  st_waddr;
    logic [31:0] st_wdata;
    logic [1:0]  st_ok;
    logic        issue_valid, issue_we, issue_long;
    logic [3:0]  issue_waddr;
    logic        flush, lc_valid;
    logic [3:0]  lc_waddr;
    logic [15:0] lc_wdata;
    logic        stat_clr;
    logic [31:0] fwd_data;
    logic        stall_req, issue_fire;
    logic [15:0] busy;
    logic [15:0] stall_cnt;

    bit [15:0] m_busy;
    int        m_cnt;
    int        n_vec;
    int        n_err;

    id_fwd_scoreboard dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rf_data(rf_data),
        .st_we(st_we), .st_waddr(st_waddr), .st_wdata(st_wdata), .st_ok(st_ok),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_long(issue_long),
        .issue_waddr(issue_waddr), .flush(flush), .lc_valid(lc_valid),
        .lc_waddr(lc_waddr), .lc_wdata(lc_wdata), .stat_clr(stat_clr),
        .fwd_data(fwd_data), .stall_req(stall_req), .issue_fire(issue_fire),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    initial forever #5 clk = ~clk;

    // Reference: for each operand, list who may supply register a (EX, MEM, then the
    // completing long op, then the scoreboard, then the file) and take the first claimant.
    function automatic void model_eval(output logic [31:0] f, output logic s, output logic fi);
        bit haz = 0;
        bit waw;
        f = rf_data;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] a = rd_addr[i*4 +: 4];
            int owner = -1;
            if (!rd_en[i]) continue;
            for (int st = 1; st >= 0; st--)
                if (st_we[st] && st_waddr[st*4 +: 4] == a) owner = st;
            if (owner >= 0) begin
                if (st_ok[owner]) f[i*16 +: 16] = st_wdata[owner*16 +: 16];
                else begin f[i*16 +: 16] = 16'h0; haz = 1; end
            end else if (lc_valid && lc_waddr == a) begin
                f[i*16 +: 16] = lc_wdata;
            end else if (m_busy[a]) begin
                f[i*16 +: 16] = 16'h0; haz = 1;
            end
        end
        waw = issue_valid && issue_we && m_busy[issue_waddr] && !(lc_valid && lc_waddr == issue_waddr);
        s  = rst && issue_valid && (haz || waw);
        fi = rst && issue_valid && !s && !flush;
        if (!rst) f = 32'h0;
    endfunction

    task automatic tick();
        logic [31:0] f;
        logic s, fi;
        model_eval(f, s, fi);
        @(posedge clk);
        if (!rst) begin
            m_busy = '0; m_cnt = 0;
        end else begin
            if (lc_valid) m_busy[lc_waddr] = 1'b0;
            if (fi && issue_we && issue_long) m_busy[issue_waddr] = 1'b1;
            if (stat_clr) m_cnt = 0;
            else if (s && m_cnt < 65535) m_cnt++;
        end
        #1;
    endtask

    task automatic clear_inputs();
        rd_en = '0; rd_addr = '0; rf_data = '0; st_we = '0; st_waddr = '0;
        st_wdata = '0; st_ok = '0; issue_valid = 0; issue_we = 0; issue_long = 0;
        issue_waddr = '0; flush = 0; lc_valid = 0; lc_waddr = '0; lc_wdata = '0;
        stat_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        rd_en = 2'b11; rd_addr = 8'h21; rf_data = 32'hBEEF_CAFE;
        st_we = 2'b01; st_waddr = 8'h01; st_ok = 2'b00; issue_valid = 1;
        #2;
        n_vec++; if (busy !== 16'h0) begin n_err++; $display("FAIL reset_busy got=%h exp=0000", busy); end
        n_vec++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt got=%h exp=0000", stall_cnt); end
        n_vec++; if (fwd_data !== 32'h0) begin n_err++; $display("FAIL reset_fwd got=%h exp=0", fwd_data); end
        n_vec++; if (stall_req !== 1'b0 || issue_fire !== 1'b0) begin
            n_err++; $display("FAIL reset_ctl got stall=%b fire=%b exp 0 0", stall_req, issue_fire);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        m_busy = '0; m_cnt = 0;
        tick();
    endtask

    task automatic test_bypass();
        clear_inputs();
        rd_en = 2'b01; rd_addr = 8'h03; rf_data = 32'h0000_AAAA;
        st_we = 2'b11; st_waddr = 8'h33; st_wdata = 32'h2222_1111; st_ok = 2'b11;
        issue_valid = 1;
        #1;
        n_vec++; if (fwd_data[15:0] !== 16'h1111 || stall_req !== 1'b0) begin
            n_err++; $display("FAIL bypass_young got=%h stall=%b exp=1111 0", fwd_data[15:0], stall_req);
        end
        st_we = 2'b10; #1;
        n_vec++; if (fwd_data[15:0] !== 16'h2222) begin
            n_err++; $display("FAIL bypass_old got=%h exp=2222", fwd_data[15:0]);
        end
        st_we = 2'b00; #1;
        n_vec++; if (fwd_data[15:0] !== 16'hAAAA) begin
            n_err++; $display("FAIL bypass_rf got=%h exp=aaaa", fwd_data[15:0]);
        end
        rd_en = 2'b00; st_we = 2'b01; st_ok = 2'b00; #1;
        n_vec++; if (fwd_data[15:0] !== 16'hAAAA || stall_req !== 1'b0) begin
            n_err++; $display("FAIL bypass_rd_off got=%h stall=%b exp=aaaa 0", fwd_data[15:0], stall_req);
        end
        tick();
    endtask

    task automatic test_load_use();
        int c0;
        clear_inputs();
        stat_clr = 1; tick(); stat_clr = 0;
        c0 = m_cnt;
        rd_en = 2'b10; rd_addr = 8'h20; rf_data = 32'h7777_0000;
        st_we = 2'b11; st_waddr = 8'h22; st_wdata = 32'h5555_1234; st_ok = 2'b10;
        issue_valid = 1;
        #1;
        n_vec++; if (stall_req !== 1'b1 || fwd_data[31:16] !== 16'h0 || issue_fire !== 1'b0) begin
            n_err++; $display("FAIL load_use got stall=%b fwd1=%h fire=%b exp 1 0000 0",
                              stall_req, fwd_data[31:16], issue_fire);
        end
        for (int k = 0; k < 3; k++) tick();
        n_vec++; if (stall_cnt !== 16'(c0 + 3)) begin
            n_err++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, c0 + 3);
        end
        st_ok = 2'b11; st_wdata = 32'h5555_5555; #1;
        n_vec++; if (stall_req !== 1'b0 || fwd_data[31:16] !== 16'h5555 || issue_fire !== 1'b1) begin
            n_err++; $display("FAIL load_use_rel got stall=%b fwd1=%h fire=%b exp 0 5555 1",
                              stall_req, fwd_data[31:16], issue_fire);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        clear_inputs();
        issue_valid = 1; issue_we = 1; issue_long = 1; issue_waddr = 4'd9;
        tick();
        clear_inputs();
        n_vec++; if (busy[9] !== 1'b1) begin n_err++; $display("FAIL sb_set got=%b exp=1", busy[9]); end
        rd_en = 2'b01; rd_addr = 8'h09; rf_data = 32'h0000_3333; issue_valid = 1; #1;
        n_vec++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL sb_stall got=%b exp=1", stall_req); end
        flush = 1; #1;
        n_vec++; if (stall_req !== 1'b1 || issue_fire !== 1'b0) begin
            n_err++; $display("FAIL sb_flush got stall=%b fire=%b exp 1 0", stall_req, issue_fire);
        end
        flush = 0; lc_valid = 1; lc_waddr = 4'd9; lc_wdata = 16'h00FE; #1;
        n_vec++; if (fwd_data[15:0] !== 16'h00FE || stall_req !== 1'b0) begin
            n_err++; $display("FAIL sb_lc got=%h stall=%b exp=00fe 0", fwd_data[15:0], stall_req);
        end
        tick();
        lc_valid = 0;
        n_vec++; if (busy[9] !== 1'b0) begin n_err++; $display("FAIL sb_clr got=%b exp=0", busy[9]); end
    endtask

    task automatic test_waw();
        clear_inputs();
        issue_valid = 1; issue_we = 1; issue_long = 1; issue_waddr = 4'd4;
        tick();
        #1;
        n_vec++; if (stall_req !== 1'b1 || issue_fire !== 1'b0) begin
            n_err++; $display("FAIL waw_stall got stall=%b fire=%b exp 1 0", stall_req, issue_fire);
        end
        lc_valid = 1; lc_waddr = 4'd4; lc_wdata = 16'h0444; #1;
        n_vec++; if (stall_req !== 1'b0 || issue_fire !== 1'b1) begin
            n_err++; $display("FAIL waw_lc got stall=%b fire=%b exp 0 1", stall_req, issue_fire);
        end
        tick();
        n_vec++; if (busy[4] !== 1'b1) begin n_err++; $display("FAIL waw_setclr got=%b exp=1", busy[4]); end
        clear_inputs();
        lc_valid = 1; lc_waddr = 4'd4; lc_waddr = 4'd4;
        tick();
        lc_valid = 1; lc_waddr = 4'd7;
        tick();
        n_vec++; if (busy !== 16'h0) begin n_err++; $display("FAIL lc_idle got=%h exp=0000", busy); end
        clear_inputs();
    endtask

    task automatic test_counter();
        clear_inputs();
        stat_clr = 1; tick(); stat_clr = 0;
        n_vec++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL cnt_clr0 got=%h exp=0000", stall_cnt); end
        rd_en = 2'b01; rd_addr = 8'h05; st_we = 2'b01; st_waddr = 8'h05; st_ok = 2'b00;
        issue_valid = 1;
        for (int k = 0; k < 65535; k++) tick();
        n_vec++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL cnt_full got=%h exp=ffff", stall_cnt); end
        tick(); tick();
        n_vec++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL cnt_sat got=%h exp=ffff", stall_cnt); end
        stat_clr = 1; tick(); stat_clr = 0;
        n_vec++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL cnt_clr_stall got=%h exp=0000", stall_cnt); end
        tick();
        n_vec++; if (stall_cnt !== 16'h1) begin n_err++; $display("FAIL cnt_inc got=%h exp=0001", stall_cnt); end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [31:0] ef;
        logic es, efi;
        clear_inputs();
        for (int n = 0; n < 3000; n++) begin
            rd_en       = 2'($urandom);
            rd_addr     = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 6))};
            rf_data     = $urandom;
            st_we       = 2'($urandom);
            st_waddr    = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 6))};
            st_wdata    = $urandom;
            st_ok       = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_we    = 1'($urandom);
            issue_long  = ($urandom_range(0, 2) == 0);
            issue_waddr = 4'($urandom_range(0, 6));
            flush       = ($urandom_range(0, 7) == 0);
            lc_valid    = ($urandom_range(0, 2) == 0);
            lc_waddr    = 4'($urandom_range(0, 6));
            lc_wdata    = 16'($urandom);
            stat_clr    = ($urandom_range(0, 31) == 0);
            #1;
            model_eval(ef, es, efi);
            n_vec++; if (fwd_data !== ef || stall_req !== es || issue_fire !== efi) begin
                n_err++;
                $display("FAIL rand_comb n=%0d got fwd=%h stall=%b fire=%b exp fwd=%h stall=%b fire=%b",
                         n, fwd_data, stall_req, issue_fire, ef, es, efi);
            end
            tick();
            n_vec++; if (busy !== m_busy || stall_cnt !== 16'(m_cnt)) begin
                n_err++;
                $display("FAIL rand_state n=%0d got busy=%h cnt=%h exp busy=%h cnt=%h",
                         n, busy, stall_cnt, m_busy, 16'(m_cnt));
            end
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        m_busy = '0; m_cnt = 0;
        tick();
        issue_valid = 1; issue_we = 1; issue_long = 1; issue_waddr = 4'd4; tick();
        issue_waddr = 4'd9; tick();
        clear_inputs();
        n_vec++; if (busy !== 16'h0210) begin n_err++; $display("FAIL ar_pre got=%h exp=0210", busy); end
        rd_en = 2'b01; rd_addr = 8'h04; rf_data = 32'h0000_4444; issue_valid = 1; #1;
        n_vec++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL ar_stall got=%b exp=1", stall_req); end
        #1 rst = 1'b0;
        m_busy = '0; m_cnt = 0;
        #1;
        n_vec++; if (busy !== 16'h0 || stall_cnt !== 16'h0 || stall_req !== 1'b0 || issue_fire !== 1'b0) begin
            n_err++; $display("FAIL ar_assert got busy=%h cnt=%h stall=%b fire=%b exp 0000 0000 0 0",
                              busy, stall_cnt, stall_req, issue_fire);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (fwd_data[15:0] !== 16'h4444 || stall_req !== 1'b0 || issue_fire !== 1'b1) begin
            n_err++; $display("FAIL ar_release got fwd0=%h stall=%b fire=%b exp 4444 0 1",
                              fwd_data[15:0], stall_req, issue_fire);
        end
        tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_busy = '0; m_cnt = 0;
        test_reset();
        test_bypass();
        test_load_use();
        test_scoreboard();
        test_waw();
        test_counter();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
